instr_sequencer: RTL

// Upstream feeder for the cpu datapath/controller. It holds a small program in
// a local instruction store and issues one instruction at a time on the cpu's

---
 rtl/instr_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: feeds a cpu one instruction at a time from a local store.
//
// A run starts at pc=0. Each instruction is fetched, issued with a one-cycle
// load/start pulse, and retired once the cpu's waiting flag has dropped and
// risen again. The run ends on a HALT word, which is never issued, or after
// the last store entry. A wait that outlasts Timeout cycles latches err until
// reset.
//
// Ports
//   clk_i      rising-edge clock
//   rst_ni     synchronous active-low reset
//   wr_en_i    store write strobe, ignored while busy
//   wr_addr_i  store write address
//   wr_data_i  store write data
//   run_i      start a run at pc=0 (IDLE/DONE only)
//   waiting_i  cpu is idle in its wait state
//   instr_o    instruction to cpu, updated in FETCH
//   load_o     one-cycle pulse in ISSUE
//   start_o    one-cycle pulse in ISSUE
//   pc_o       index of current instruction
//   retired_o  instructions completed this run
//   busy_o     run in progress
//   done_o     run finished
//   err_o      handshake timeout (sticky)
module instr_sequencer #(
    parameter int unsigned    Depth     = 16,
    parameter logic [15:0]    HaltInstr = 16'hE000,
    parameter int unsigned    Timeout   = 15,
    localparam int unsigned   AW        = $clog2(Depth)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [15:0]   wr_data_i,
    input  logic          run_i,
    input  logic          waiting_i,
    output logic [15:0]   instr_o,
    output logic          load_o,
    output logic          start_o,
    output logic [AW-1:0] pc_o,
    output logic [AW:0]   retired_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int unsigned TW = $clog2(Timeout + 1);
    localparam logic [TW-1:0] TimerLast = TW'(Timeout - 1);
    localparam logic [TW-1:0] TimerOne  = TW'(1);
    localparam logic [AW-1:0] PcLast    = AW'(Depth - 1);
    localparam logic [AW-1:0] PcOne     = AW'(1);
    localparam logic [AW:0]   RetOne    = (AW + 1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StDone,
        StError
    } state_e;

    state_e        state_q;
    logic [15:0]   instr_q;
    logic          load_q;
    logic          start_q;
    logic [AW-1:0] pc_q;
    logic [AW:0]   retired_q;
    logic          err_q;
    logic [TW-1:0] timer_q;

    logic [15:0]   mem_q [Depth];
    logic [15:0]   rd_data;
    logic          busy;

    assign busy    = (state_q == StFetch)    || (state_q == StIssue) ||
                     (state_q == StWaitBusy) || (state_q == StWaitDone);
    assign rd_data = mem_q[pc_q];

    // Store has no reset; writes are dropped while a run is in flight.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !busy) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // The timeout fires on the Timeout-th cycle spent in a wait state, so err
    // rises Timeout+1 cycles after ISSUE when the cpu never responds.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            instr_q   <= '0;
            load_q    <= 1'b0;
            start_q   <= 1'b0;
            pc_q      <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
            timer_q   <= '0;
        end else begin
            load_q  <= 1'b0;
            start_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (run_i) begin
                        pc_q      <= '0;
                        retired_q <= '0;
                        state_q   <= StFetch;
                    end
                end
                StFetch: begin
                    instr_q <= rd_data;
                    if (rd_data == HaltInstr) begin
                        state_q <= StDone;
                    end else begin
                        // Registered pulse lines up with the ISSUE state.
                        load_q  <= 1'b1;
                        start_q <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    timer_q <= '0;
                    state_q <= StWaitBusy;
                end
                StWaitBusy: begin
                    if (!waiting_i) begin
                        timer_q <= '0;
                        state_q <= StWaitDone;
                    end else if (timer_q == TimerLast) begin
                        err_q   <= 1'b1;
                        state_q <= StError;
                    end else begin
                        timer_q <= timer_q + TimerOne;
                    end
                end
                StWaitDone: begin
                    if (waiting_i) begin
                        retired_q <= retired_q + RetOne;
                        if (pc_q == PcLast) begin
                            state_q <= StDone;
                        end else begin
                            pc_q    <= pc_q + PcOne;
                            state_q <= StFetch;
                        end
                    end else if (timer_q == TimerLast) begin
                        err_q   <= 1'b1;
                        state_q <= StError;
                    end else begin
                        timer_q <= timer_q + TimerOne;
                    end
                end
                StError: begin
                    state_q <= StError;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign instr_o   = instr_q;
    assign load_o    = load_q;
    assign start_o   = start_q;
    assign pc_o      = pc_q;
    assign retired_o = retired_q;
    assign busy_o    = busy;
    assign done_o    = (state_q == StDone);
    assign err_o     = err_q;

endmodule
